config_serial_rx: RTL

Multi-lane serial configuration receiver for the fabric's bitstream load path. Oversamples the external `s_clk`/`s_data` pins in the system clock domain. Data bits are captured on `s_clk` rising edges and control bits on falling edges. Each completed word is delivered through a valid/ready port to the frame writer only if its control word matches `CTRL_WORD`. This is the parametrised successor of the single-lane 32-bit/0xFAB1 loader, adding lanes, a handshake, error flags and idle resync.

---
 rtl/config_serial_rx_if.sv | 12 +
 rtl/config_serial_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/config_serial_rx_if.sv
// Word delivery port of config_serial_rx: received word plus valid/ready handshake.
interface config_serial_rx_if #(
    parameter int unsigned LANES  = 1,
    parameter int unsigned WORD_W = 32
);
    logic [LANES*WORD_W-1:0] word_o;
    logic                    word_valid_o;
    logic                    word_ready_i;

    modport master (output word_o, output word_valid_o, input word_ready_i);
    modport slave  (input word_o, input word_valid_o, output word_ready_i);
endinterface

// File: rtl/config_serial_rx.sv
// Multi-lane serial configuration receiver: oversampled s_clk/s_data, data on rise, ctrl on fall.
// Optional idle-timeout discard of partial words is enabled by defining CFG_RX_TIMEOUT_EN.
module config_serial_rx #(
    parameter int unsigned LANES       = 1,
    parameter int unsigned WORD_W      = 32,
    parameter logic [31:0] CTRL_WORD   = 32'h0000FAB1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_clk,
    input  logic [LANES-1:0]     s_data,
    input  logic                 enable,
    input  logic                 clear_i,
    config_serial_rx_if.master   word_if,
    output logic [15:0]          word_count_o,
    output logic                 ctrl_err_o,
    output logic                 overrun_o,
    output logic                 timeout_o
);

    localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [WORD_W-1:0] CTRL_LO = WORD_W'(CTRL_WORD);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WORD_W - 1);

    logic                    sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic [LANES-1:0]        data_meta_q, data_sync_q;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [LANES*WORD_W-1:0] data_sr_q, data_sr_d;
    logic [WORD_W-1:0]       ctrl_sr_q, ctrl_sr_d;
    logic                    done_q, done_d;
    logic [LANES*WORD_W-1:0] word_q, word_d;
    logic                    valid_q, valid_d;
    logic [15:0]             count_q, count_d;
    logic                    cerr_q, cerr_d;
    logic                    ovr_q, ovr_d;
    logic                    rise, fall, last_bit;

`ifdef CFG_RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              rise_seen_q, rise_seen_d;
    logic              tmo_q, tmo_d;
`endif

    assign rise     = sclk_sync_q & ~sclk_prev_q;
    assign fall     = ~sclk_sync_q & sclk_prev_q;
    assign last_bit = (bit_cnt_q == LAST_BIT);

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        data_sr_d = data_sr_q;
        ctrl_sr_d = ctrl_sr_q;
        done_d    = 1'b0;
        word_d    = word_q;
        valid_d   = valid_q;
        count_d   = count_q;
        cerr_d    = cerr_q;
        ovr_d     = ovr_q;
`ifdef CFG_RX_TIMEOUT_EN
        idle_d      = idle_q;
        rise_seen_d = rise_seen_q;
        tmo_d       = tmo_q;
`endif

        if (!enable) begin
            bit_cnt_d = '0;
            data_sr_d = '0;
            ctrl_sr_d = '0;
        end else begin
            if (rise) begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    data_sr_d[k*WORD_W +: WORD_W] = {data_sr_q[k*WORD_W +: WORD_W-1], data_sync_q[k]};
                end
            end
            if (fall) begin
                ctrl_sr_d = {ctrl_sr_q[WORD_W-2:0], data_sync_q[0]};
                if (last_bit) begin
                    bit_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
        end

        // Clear first so that a flag raised in the same cycle still reads 1 afterwards.
        if (clear_i) begin
            count_d = '0;
            cerr_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef CFG_RX_TIMEOUT_EN
            tmo_d   = 1'b0;
`endif
        end

`ifdef CFG_RX_TIMEOUT_EN
        if (!enable) begin
            idle_d      = '0;
            rise_seen_d = 1'b0;
        end else if (rise || fall) begin
            idle_d = '0;
            if (rise) rise_seen_d = 1'b1;
            if (fall && last_bit) rise_seen_d = 1'b0;
        end else if ((bit_cnt_q != '0) || rise_seen_q) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                idle_d      = '0;
                rise_seen_d = 1'b0;
                bit_cnt_d   = '0;
                data_sr_d   = '0;
                ctrl_sr_d   = '0;
                tmo_d       = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
`endif

        if (valid_q && word_if.word_ready_i) valid_d = 1'b0;

        // done_q trails the completing fall by one cycle, so ctrl/data registers already hold the full word.
        if (done_q) begin
            if (ctrl_sr_q == CTRL_LO) begin
                if (!valid_q || word_if.word_ready_i) begin
                    word_d  = data_sr_q;
                    valid_d = 1'b1;
                    if (count_d != 16'hFFFF) count_d = count_d + 16'd1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                cerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            data_meta_q <= '0;
            data_sync_q <= '0;
            bit_cnt_q   <= '0;
            data_sr_q   <= '0;
            ctrl_sr_q   <= '0;
            done_q      <= 1'b0;
            word_q      <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
            cerr_q      <= 1'b0;
            ovr_q       <= 1'b0;
`ifdef CFG_RX_TIMEOUT_EN
            idle_q      <= '0;
            rise_seen_q <= 1'b0;
            tmo_q       <= 1'b0;
`endif
        end else begin
            sclk_meta_q <= s_clk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            data_meta_q <= s_data;
            data_sync_q <= data_meta_q;
            bit_cnt_q   <= bit_cnt_d;
            data_sr_q   <= data_sr_d;
            ctrl_sr_q   <= ctrl_sr_d;
            done_q      <= done_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            cerr_q      <= cerr_d;
            ovr_q       <= ovr_d;
`ifdef CFG_RX_TIMEOUT_EN
            idle_q      <= idle_d;
            rise_seen_q <= rise_seen_d;
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign word_if.word_o       = word_q;
    assign word_if.word_valid_o = valid_q;
    assign word_count_o         = count_q;
    assign ctrl_err_o           = cerr_q;
    assign overrun_o            = ovr_q;
`ifdef CFG_RX_TIMEOUT_EN
    assign timeout_o            = tmo_q;
`else
    assign timeout_o            = 1'b0;
`endif

endmodule
